icache_direct: RTL
==================

# icache_direct

Direct-mapped, 16-entry, one-word-per-block instruction cache between the fetch stage and the memory controller's instruction port. Uses the `icachef_t` split of `cpu_types_pkg`: 26-bit tag, 4-bit index, 2-bit byte offset.
- On a hit it returns the instruction combinationally.
- On a miss it runs a single blocking fetch through the memory controller's iREN/iwait handshake.
- It then fills the frame.

## Interface
Parameters (fixed by `cpu_types_pkg`, not overridable):
- ITAG_W, 26, tag width
- IIDX_W, 4, index width; 2**IIDX_W = 16 frames
- IBYT_W, 2, byte offset width; ignored for lookup

Ports:
- CLK  in  1  clock. One clock domain only.
- RST  in  1  reset. Synchronous and active-high.
- imemREN  in  1  fetch stage requests an instruction
- imemaddr  in  32 (word_t)  fetch address
- iflush  in  1  invalidate all frames
- ihit  out  1  `imemload` is valid this cycle
- imemload  out  32 (word_t)  instruction; 0 when ihit=0
- iREN  out  1  read request to the memory controller
- iaddr  out  32 (word_t)  memory read address, word aligned
- iwait  in  1  memory busy; a low level while iREN=1 means iload is valid
- iload  in  32 (word_t)  memory read data
- hit_count, miss_count  out  32 each  present only with ICACHE_STATS_EN

## Operation
- Frame contents: valid, tag[25:0], data[31:0].
- Address split: idx = imemaddr[5:2], tag = imemaddr[31:6]. imemaddr[1:0] is ignored.
- FSM type: `icache_state_t`. States are LOOKUP and FETCH. Reset state is LOOKUP.
- **LOOKUP**
  - Hit condition: imemREN & frame[idx].valid & frame[idx].tag==tag. On a hit, ihit=1 and imemload=frame[idx].data. No state change.
  - Miss condition: imemREN=1 and not a hit. On a miss, ihit=0, miss_addr <= {imemaddr[31:2],2'b00}, and the next state is FETCH.
  - imemREN=0: idle. ihit=0, iREN=0.
- **FETCH**
  - Outputs: iREN=1 and iaddr=miss_addr.
  - While iwait=1, stay in FETCH.
  - When iwait=0, write frame[miss_addr idx] <= {1, miss_addr tag, iload}, then go to LOOKUP.
  - ihit=0 throughout FETCH.
- Fetch completion is not abortable. If imemREN drops or imemaddr changes during FETCH, the fill still completes with the latched miss_addr. A later lookup then re-evaluates the current address.
- iflush clears every valid bit at the next edge, in any state.
  - If iflush coincides with the fill edge, flush wins and the frame stays invalid.
  - If iflush is asserted during FETCH, the FSM still finishes the memory transaction.
- Outside FETCH, iaddr = miss_addr and iREN=0.

## Timing
- Reset values: all valid bits 0, state LOOKUP, miss_addr 0, ihit 0, imemload 0, iREN 0, iaddr 0. Counters are 0 when present.
- Hit latency is 0 cycles; ihit is combinational in the same cycle as the request.
- Miss latency is 1 cycle (LOOKUP→FETCH) + N cycles with iwait=1 + 1 fill edge. A hit follows in the first LOOKUP cycle. With N=0 the instruction arrives 2 cycles after the request.
- iREN rises on the cycle after the miss is detected. It falls on the cycle after the edge where iwait=0 was sampled.
- RST asserted during FETCH:
  - iREN=0 and LOOKUP from the next cycle.
  - All frames are invalid.
  - The in-flight data is discarded.
- Tag and data arrays are registers with a single write port and a single asynchronous read port. Tag and data are never read and written at the same index in the same cycle except in the FETCH→LOOKUP transition, and the lookup in that transition is suppressed.

## Configuration
- Macro: `ICACHE_STATS_EN`.
- Defined:
  - hit_count and miss_count ports exist.
  - hit_count increments once per cycle with ihit=1.
  - miss_count increments once per LOOKUP→FETCH transition.
  - Both are cleared by RST only, not by iflush, and wrap at 2**32.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
Add to `cpu_types_pkg`:
- `icache_state_t` (enum: LOOKUP, FETCH)
- `ICACHE_SETS` = 2**IIDX_W
- `icache_frame_t` (packed struct: valid, tag[ITAG_W-1:0], data word_t)

The one natural sub-module is `icache_array`. It holds the 16 `icache_frame_t` entries and has one async read port, one write port, and a flash-clear input. The FSM, the miss_addr register and the counters stay in `icache_direct`.

## Test plan
- Cold miss then hit:
  - Stimulus: imemREN=1, imemaddr=0x0000_0040, memory returns 0x2001_0005 after 3 wait cycles.
  - Response: iREN high for 4 cycles with iaddr=0x40, then ihit=1 with imemload=0x2001_0005.
  - With ICACHE_STATS_EN: miss_count=1.
- Conflict eviction:
  - Stimulus: fill 0x0000_0040, then request 0x0000_0080 (same idx 0, different tag), then 0x40 again.
  - Response: two further misses with iaddr=0x80 then 0x40. Each refill is returned correctly.
- Byte-offset ignore: after filling 0x40, request 0x43. Response: immediate ihit=1 and no iREN.
- Flush during fetch:
  - Stimulus: assert iflush on the same edge that iwait falls.
  - Response: the frame stays invalid and a re-request of the same address misses again.
- Reset mid-fetch:
  - Stimulus: RST=1 for 1 cycle while in FETCH with iwait=1.
  - Response: the next cycle has iREN=0, ihit=0 and iaddr=0. A subsequent request misses.
- Address change during fetch:
  - Stimulus: switch imemaddr from 0x100 to 0x200 during FETCH.
  - Response: iaddr holds 0x100 until the fill completes. A new miss to 0x200 follows.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: fetch-address split and instruction-cache frame/FSM types.
package cpu_types_pkg;

  localparam int unsigned ITAG_W      = 26;
  localparam int unsigned IIDX_W      = 4;
  localparam int unsigned IBYT_W      = 2;
  localparam int unsigned ICACHE_SETS = 2 ** IIDX_W;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [IBYT_W-1:0] bytoff;
  } icachef_t;

  typedef enum logic {
    LOOKUP,
    FETCH
  } icache_state_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

  function automatic word_t word_align(word_t addr);
    return {addr[31:IBYT_W], {IBYT_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Frame storage for icache_direct: one async read port, one write port, flash-clear of valids.
module icache_array
  import cpu_types_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              we_i,
  input  logic [IIDX_W-1:0] widx_i,
  input  icache_frame_t     wframe_i,
  input  logic [IIDX_W-1:0] ridx_i,
  output icache_frame_t     rframe_o
);

  icache_frame_t frames_q [ICACHE_SETS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ICACHE_SETS; i++) begin
        frames_q[i] <= '0;
      end
    end else begin
      if (we_i) begin
        frames_q[widx_i] <= wframe_i;
      end
      // Flush is applied after the write so a coincident fill leaves the frame invalid.
      if (flush_i) begin
        for (int i = 0; i < ICACHE_SETS; i++) begin
          frames_q[i].valid <= 1'b0;
        end
      end
    end
  end

  assign rframe_o = frames_q[ridx_i];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped 16-frame instruction cache with a blocking single-word refill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  icache_state_t state_q, state_d;
  word_t         miss_addr_q, miss_addr_d;
  icachef_t      req, fill;
  icache_frame_t rframe, wframe;
  logic          lookup_hit, lookup_miss, fill_en;
  logic          unused_byt;

  assign req        = icachef_t'(imemaddr);
  assign fill       = icachef_t'(miss_addr_q);
  assign unused_byt = ^{req.bytoff, fill.bytoff};

  assign lookup_hit  = (state_q == LOOKUP) && imemREN && rframe.valid && (rframe.tag == req.tag);
  assign lookup_miss = (state_q == LOOKUP) && imemREN && !lookup_hit;
  assign fill_en     = (state_q == FETCH) && !iwait;

  assign wframe = '{valid: 1'b1, tag: fill.tag, data: iload};

  icache_array u_array (
    .clk_i    (CLK),
    .rst_i    (RST),
    .flush_i  (iflush),
    .we_i     (fill_en),
    .widx_i   (fill.idx),
    .wframe_i (wframe),
    .ridx_i   (req.idx),
    .rframe_o (rframe)
  );

  assign ihit     = lookup_hit;
  assign imemload = lookup_hit ? rframe.data : '0;
  assign iREN     = (state_q == FETCH);
  assign iaddr    = miss_addr_q;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    unique case (state_q)
      LOOKUP: begin
        if (lookup_miss) begin
          state_d     = FETCH;
          miss_addr_d = word_align(imemaddr);
        end
      end
      FETCH: begin
        // The refill is never aborted; it always completes with the latched address.
        if (!iwait) begin
          state_d = LOOKUP;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= LOOKUP;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (lookup_hit) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (lookup_miss) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
